counter_seek_arbiter: RTL and testbench
=======================================

// Module: counter_seek_arbiter
// PURPOSE
//  Shares one up/down step counter between two requesters. Each requester asks
//  for a target value. The block grants requesters round-robin and drives the
//  counter to the target along the shorter wrap-around path, moving by 2 while
//  the remaining distance is >=2. It pulses ack when the counter has arrived.
//  Sits between request logic and the counter datapath, which it owns.
// PARAMETERS
//  WIDTH     4   counter width in bits, >=2; the counter wraps modulo 2**WIDTH
// PORTS
//  clk       in   1      single clock; all state changes on rising edge
//  nrst      in   1      asynchronous active-low reset
//  req       in   2      req[i]: requester i wants the counter; held until ack[i]
//  target0   in   WIDTH  target of requester 0; sampled only at grant
//  target1   in   WIDTH  target of requester 1; sampled only at grant
//  ack       out  2      one-cycle pulse: granted requester's target reached
//  busy      out  1      1 in SEEK and DONE
//  grant_id  out  1      index of current/last granted requester
//  value     out  WIDTH  current counter value
// BEHAVIOUR
//  Reset (async, nrst=0): state=IDLE, value=0, ack=0, busy=0, grant_id=1
//   (so requester 0 wins first). Reset mid-seek abandons the seek; no ack.
//  States:
//  - IDLE: counter enable=0.
//    - No req bit set: stay in IDLE.
//    - Any req bit set: grant on the next edge and go to SEEK.
//    - Both set: the winner is the one != grant_id (round-robin).
//    - On grant: latch grant_id, tgt_q<=target[winner], dir_q.
//    - dist_up=(tgt-value) mod 2**WIDTH; dir_q=down iff dist_up > 2**(WIDTH-1).
//    - Tie at exactly half range goes up.
//  - SEEK:
//    - rem = dir_q ? (value-tgt_q) : (tgt_q-value), mod 2**WIDTH.
//    - rem==0: enable=0, next DONE.
//    - Else: enable=1, down=dir_q, step=(rem>=2); value moves by 2 or 1.
//    - Wrap through 0 / 2**WIDTH-1 is normal modular arithmetic.
//  - DONE: ack[grant_id]=1 for exactly this cycle; enable=0; next IDLE.
//    - A req still high in the same cycle as its ack is ignored in IDLE only if
//      the requester drops it. Requesters must drop req the cycle after ack.
//  Latency: req sampled in IDLE at cycle c gives ack in cycle c+ceil(d/2)+2,
//   where d is the shorter-path distance. d=0 gives ack at c+2.
//  Simultaneous events:
//  - A req arriving while busy waits, with no loss.
//  - Dropping the granted req mid-seek does not abort; ack still pulses.
//  - Target changes after grant are ignored.
//  Counter never moves outside SEEK; value holds in IDLE/DONE.
// STRUCTURE
//  - Package counter_ctrl_pkg: typedef enum {IDLE,SEEK,DONE} seek_state_t;
//    localparam NREQ=2.
//  - Sub-module updown_counter_en. Ports: clk, nrst, en, step, down, out[WIDTH].
//    - en=0 holds the value.
//    - en=1 adds or subtracts (step?2:1) modulo 2**WIDTH.
//    - Async reset to 0.
//  - Top: FSM + arbiter + distance compare, one counter instance.
// TESTING
//  1 Reset, value=0, req=01, target0=5 -> up path, value 0,2,4,5; ack=01 at c+5.
//  2 value=14, req=10, target1=1 -> up via wrap, value 14,0,1; ack=10 at c+4.
//  3 value=1, target0=14 -> down, value 1,15,14; ack at c+4.
//  4 value=0, target0=8 (tie) -> up, value 0,2,4,6,8.
//  5 target0=value -> no counter motion; ack=01 at c+2.
//  6 req=11 held, targets 3/9 -> order 0,1,0,1 alternating grants.
//  7 nrst low mid-SEEK -> value=0, ack=0 at once, back in IDLE.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter seek arbiter: FSM states and requester count.
package counter_ctrl_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEEK = 2'd1,
        DONE = 2'd2
    } seek_state_t;

endpackage

// File: rtl/updown_counter_en.sv
// Modular up/down counter moving by 1 or 2 per enabled cycle.
module updown_counter_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             step,
    input  logic             down,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_delta;

    assign w_delta = step ? WIDTH'(2) : WIDTH'(1);
    assign out     = r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_cnt <= '0;
        else if (en)
            r_cnt <= down ? (r_cnt - w_delta) : (r_cnt + w_delta);
    end

endmodule

// File: rtl/counter_seek_arbiter.sv
// Round-robin arbiter that seeks a shared counter to the granted requester's
// target along the shorter wrap-around path, then pulses that requester's ack.
module counter_seek_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] target0,
    input  logic [WIDTH-1:0] target1,
    output logic [NREQ-1:0]  ack,
    output logic             busy,
    output logic             grant_id,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] HALF = WIDTH'(1) << (WIDTH - 1);

    seek_state_t      r_state, w_next_state;
    logic [WIDTH-1:0] r_tgt;
    logic             r_dir;
    logic             r_gid;

    logic             w_grant;
    logic             w_en;
    logic             w_step;
    logic             w_winner;
    logic [WIDTH-1:0] w_tgt_win;
    logic [WIDTH-1:0] w_dist_up;
    logic [WIDTH-1:0] w_rem;

    // Single requester wins outright; a tie goes to the one not granted last.
    assign w_winner  = (&req) ? ~r_gid : req[1];
    assign w_tgt_win = w_winner ? target1 : target0;
    assign w_dist_up = w_tgt_win - value;

    // Exactly half range is left as "up" because the compare is strict.
    assign w_rem  = r_dir ? (value - r_tgt) : (r_tgt - value);
    assign w_step = (w_rem >= WIDTH'(2));

    assign busy     = (r_state == SEEK) || (r_state == DONE);
    assign grant_id = r_gid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_en         = 1'b0;
        ack          = '0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_grant      = 1'b1;
                    w_next_state = SEEK;
                end
            end
            SEEK: begin
                if (w_rem == '0)
                    w_next_state = DONE;
                else
                    w_en = 1'b1;
            end
            DONE: begin
                ack[r_gid]   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_gid <= 1'b1;
            r_tgt <= '0;
            r_dir <= 1'b0;
        end else if (w_grant) begin
            r_gid <= w_winner;
            r_tgt <= w_tgt_win;
            r_dir <= (w_dist_up > HALF);
        end
    end

    updown_counter_en #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .nrst (nrst),
        .en   (w_en),
        .step (w_step),
        .down (r_dir),
        .out  (value)
    );

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Bench for counter_seek_arbiter: directed and random seeks checked against a
// distance/latency model of the shorter-path seek.
module tb_counter_seek_arbiter;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk;
    logic         nrst;
    logic [1:0]   req;
    logic [W-1:0] target0, target1;
    logic [1:0]   ack;
    logic         busy;
    logic         grant_id;
    logic [W-1:0] value;

    int n_cmp = 0;
    int n_err = 0;
    int model_val = 0;
    int model_gid = 1;

    counter_seek_arbiter #(.WIDTH(W)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .req      (req),
        .target0  (target0),
        .target1  (target1),
        .ack      (ack),
        .busy     (busy),
        .grant_id (grant_id),
        .value    (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One grant: drive mask in an IDLE cycle, then check every cycle up to ack.
    // At idx 1 req is modified by late_set/late_clr and targets are scrambled.
    task automatic seek_txn(input logic [1:0] mask, input int t0, input int t1,
                            input logic [1:0] late_set, input logic [1:0] late_clr);
        int win, v0, tg, up, d, lat, moved, ev;
        bit dn;
        logic [1:0] eack;
        logic [8:0] expv, got;
        @(posedge clk); #1;
        req = mask; target0 = W'(t0); target1 = W'(t1);
        win = (mask == 2'b11) ? (model_gid == 1 ? 0 : 1) : (mask[1] ? 1 : 0);
        tg  = win ? t1 : t0;
        v0  = model_val;
        up  = (tg - v0 + M) % M;
        dn  = (up > M / 2);
        d   = dn ? (M - up) : up;
        lat = (d + 1) / 2 + 2;
        for (int idx = 0; idx <= lat; idx++) begin
            @(negedge clk);
            moved = (idx < 2) ? 0 : ((2 * (idx - 1) < d) ? 2 * (idx - 1) : d);
            ev    = dn ? (v0 - moved + M) % M : (v0 + moved) % M;
            eack  = (idx == lat) ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;
            expv  = {eack, 1'(idx >= 1), 1'(idx >= 1 ? win : model_gid), 4'(ev)};
            got   = {ack, busy, grant_id, value};
            n_cmp++;
            if (got !== expv) begin
                n_err++;
                $display("FAIL seek tgt=%0d idx=%0d: got ack=%b busy=%b gid=%b val=%0d, want ack=%b busy=%b gid=%b val=%0d",
                         tg, idx, got[8:7], got[6], got[5], got[3:0],
                         expv[8:7], expv[6], expv[5], expv[3:0]);
            end
            if (idx == 1) begin
                req     = (req | late_set) & ~late_clr;
                target0 = W'($urandom);
                target1 = W'($urandom);
            end
        end
        model_val = tg;
        model_gid = win;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        n_cmp++;
        if ({ack, busy, value} !== {2'b00, 1'b0, 4'(model_val)}) begin
            n_err++;
            $display("FAIL idle: got ack=%b busy=%b val=%0d, want ack=00 busy=0 val=%0d",
                     ack, busy, value, model_val);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; req = 2'b01; target0 = 4'd7; target1 = 4'd3;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ack, busy, grant_id, value} !== {2'b00, 1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL reset: got ack=%b busy=%b gid=%b val=%0d, want ack=00 busy=0 gid=1 val=0",
                     ack, busy, grant_id, value);
        end
        req = 2'b00;
        @(posedge clk); #1;
        nrst = 1'b1;
        model_val = 0; model_gid = 1;
        go_idle();
    endtask

    task automatic test_directed();
        seek_txn(2'b01, 5, 0, 2'b00, 2'b00);   // 0 -> 5 up, ack at c+5
        seek_txn(2'b01, 14, 0, 2'b00, 2'b00);  // set up value=14
        go_idle();
        seek_txn(2'b10, 0, 1, 2'b00, 2'b00);   // 14 -> 1 up through wrap
        go_idle();
        seek_txn(2'b01, 14, 0, 2'b00, 2'b00);  // 1 -> 14 down through wrap
        seek_txn(2'b01, 0, 0, 2'b00, 2'b00);
        seek_txn(2'b01, 8, 0, 2'b00, 2'b00);   // half-range tie goes up
        seek_txn(2'b01, 8, 0, 2'b00, 2'b00);   // zero distance, ack at c+2
        go_idle();
    endtask

    task automatic test_busy_queue();
        seek_txn(2'b01, 11, 2, 2'b10, 2'b00);  // req1 arrives mid-seek
        seek_txn(2'b10, 0, 2, 2'b00, 2'b00);   // then served
        go_idle();
        seek_txn(2'b10, 0, 6, 2'b00, 2'b10);   // granted req dropped mid-seek
        go_idle();
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 4; k++)
            seek_txn(2'b11, 3, 9, 2'b00, 2'b00);
        go_idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++)
            seek_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, M - 1)),
                     int'($urandom_range(0, M - 1)), 2'($urandom), 2'($urandom));
        go_idle();
    endtask

    task automatic test_reset_mid();
        int far;
        far = (model_val + 7) % M;
        @(posedge clk); #1;
        req = (model_gid == 1) ? 2'b01 : 2'b10;
        target0 = W'(far); target1 = W'(far);
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({ack, busy, grant_id, value} !== {2'b00, 1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid: got ack=%b busy=%b gid=%b val=%0d, want ack=00 busy=0 gid=1 val=0",
                     ack, busy, grant_id, value);
        end
        req = 2'b00;
        @(posedge clk); #1;
        nrst = 1'b1;
        model_val = 0; model_gid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ack, busy, value} !== {2'b00, 1'b0, 4'd0}) begin
                n_err++;
                $display("FAIL after_reset: got ack=%b busy=%b val=%0d, want ack=00 busy=0 val=0",
                         ack, busy, value);
            end
        end
        seek_txn(2'b11, 2, 12, 2'b00, 2'b00);  // requester 0 wins first again
        go_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_queue();
        test_round_robin();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
